// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES-128 controller types, sizes and the Rcon table.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  localparam int NR          = 10;
  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } ctrlState_t;

  // Indexed directly by round number; entries outside 1..10 are zero.
  localparam logic [7:0] c_RCON_TABLE [0:15] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

endpackage
`default_nettype wire

// File: rtl/aes_rcon_gen.sv
`default_nettype none
// ============================================================================
// Module   : aes_rcon_gen
// Brief    : Combinational AES key-schedule round constant from round number.
// Revision : 1.0 - initial release
// ============================================================================
module aes_rcon_gen
  import aes_pkg::*;
(
  input  logic [3:0] iRound,
  output logic [7:0] oRcon
);

  assign oRcon = c_RCON_TABLE[iRound];

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_ctrl
// Brief    : AES-128 encryption round sequencer (IDLE/INIT/ROUND/OUT) driving
//            an external datapath. Define AES_ROUND_CTRL_ABORT_EN to add the
//            iAbort input.
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int ROUND_CYCLES = 1
)
(
  input  logic       iClk,
  input  logic       iRsn,
  input  logic       iInValid,
  output logic       oInReady,
  output logic       oOutValid,
  input  logic       iOutReady,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic       iAbort,
`endif
  output logic       oLoadInit,
  output logic       oKeyLoad,
  output logic       oRoundEn,
  output logic       oKeyStep,
  output logic [3:0] oRound,
  output logic       oMixColBypass,
  output logic [7:0] oRcon
);

  localparam logic [1:0] c_LAST_SUB   = 2'(ROUND_CYCLES - 1);
  localparam logic [3:0] c_LAST_ROUND = 4'(NR);

  ctrlState_t r_state;
  ctrlState_t w_nextState;
  logic [3:0] r_round;
  logic [3:0] w_nextRound;
  logic [1:0] r_subCycle;
  logic [1:0] w_nextSubCycle;
  logic       w_lastSub;
  logic       w_abort;

  assign w_lastSub = (r_subCycle == c_LAST_SUB);

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign w_abort = iAbort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_state    <= IDLE;
      r_round    <= '0;
      r_subCycle <= '0;
    end else begin
      r_state    <= w_nextState;
      r_round    <= w_nextRound;
      r_subCycle <= w_nextSubCycle;
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_nextRound    = r_round;
    w_nextSubCycle = r_subCycle;
    oInReady       = 1'b0;
    oOutValid      = 1'b0;
    oLoadInit      = 1'b0;
    oKeyLoad       = 1'b0;
    oRoundEn       = 1'b0;
    oKeyStep       = 1'b0;
    oMixColBypass  = 1'b0;

    case (r_state)
      IDLE: begin
        oInReady       = 1'b1;
        w_nextRound    = '0;
        w_nextSubCycle = '0;
        if (iInValid) begin
          w_nextState = INIT;
        end
      end
      INIT: begin
        oLoadInit      = 1'b1;
        oKeyLoad       = 1'b1;
        w_nextState    = ROUND;
        w_nextRound    = 4'd1;
        w_nextSubCycle = '0;
      end
      ROUND: begin
        oMixColBypass = (r_round == c_LAST_ROUND);
        if (w_lastSub) begin
          oRoundEn       = 1'b1;
          oKeyStep       = 1'b1;
          w_nextSubCycle = '0;
          if (r_round == c_LAST_ROUND) begin
            w_nextState = OUT;
          end else begin
            w_nextRound = r_round + 4'd1;
          end
        end else begin
          w_nextSubCycle = r_subCycle + 2'd1;
        end
      end
      OUT: begin
        oOutValid = 1'b1;
        if (iOutReady) begin
          w_nextState = IDLE;
          w_nextRound = '0;
        end
      end
      default: begin
        w_nextState    = IDLE;
        w_nextRound    = '0;
        w_nextSubCycle = '0;
      end
    endcase

    // Abort outranks every transition but leaves this cycle's strobes intact.
    if (w_abort) begin
      w_nextState    = IDLE;
      w_nextRound    = '0;
      w_nextSubCycle = '0;
    end
  end

  assign oRound = r_round;

  aes_rcon_gen u_rconGen (
    .iRound (r_round),
    .oRcon  (oRcon)
  );

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_ctrl
// Brief    : Scoreboard bench for aes_round_ctrl (ROUND_CYCLES 1 and 3) with a
//            behavioural AES-128 datapath attached to each controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

  localparam int RC0 = 1;
  localparam int RC1 = 3;
  localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  typedef struct {
    logic [127:0] ct;
    int           lat;
    int           hold;
  } exp_t;

  logic clk;
  logic rstN;
  logic inValid [2];
  logic outReady [2];
  logic abortIn [2];
  logic inReady [2];
  logic outValid [2];
  logic loadInit [2];
  logic keyLoad [2];
  logic roundEn [2];
  logic keyStep [2];
  logic bypass [2];
  logic [3:0] roundNum [2];
  logic [7:0] rcon [2];
  logic [127:0] ptIn [2];
  logic [127:0] keyIn [2];
  logic [127:0] dpState [2];
  logic [127:0] dpKey [2];

  exp_t q0[$];
  exp_t q1[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   cyc     = 0;
  bit   mBusy [2];
  int   mAcc [2];
  int   accCyc [2];
  int   firstOut [2];
  int   outCnt [2];
  int   reCnt [2];
  int   liCnt [2];

  aes_round_ctrl #(.ROUND_CYCLES(RC0)) dut1 (
    .iClk(clk), .iRsn(rstN), .iInValid(inValid[0]), .oInReady(inReady[0]),
    .oOutValid(outValid[0]), .iOutReady(outReady[0]),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .iAbort(abortIn[0]),
`endif
    .oLoadInit(loadInit[0]), .oKeyLoad(keyLoad[0]), .oRoundEn(roundEn[0]),
    .oKeyStep(keyStep[0]), .oRound(roundNum[0]), .oMixColBypass(bypass[0]),
    .oRcon(rcon[0])
  );

  aes_round_ctrl #(.ROUND_CYCLES(RC1)) dut3 (
    .iClk(clk), .iRsn(rstN), .iInValid(inValid[1]), .oInReady(inReady[1]),
    .oOutValid(outValid[1]), .iOutReady(outReady[1]),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .iAbort(abortIn[1]),
`endif
    .oLoadInit(loadInit[1]), .oKeyLoad(keyLoad[1]), .oRoundEn(roundEn[1]),
    .oKeyStep(keyStep[1]), .oRound(roundNum[1]), .oMixColBypass(bypass[1]),
    .oRcon(rcon[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------- reference AES-128 arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int n = 0; n < 8; n++) begin
      if (b[n]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from first principles: inverse as v^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] inv;
    inv = 8'h01;
    for (int n = 0; n < 254; n++) inv = gmul(inv, v);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] nextKey(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aesRound(input logic [127:0] s, input logic [127:0] rk,
                                            input logic lastRound);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] c0, c1, c2, c3;
    logic [127:0] o;
    for (int n = 0; n < 16; n++) a[n] = sbox(s[127-8*n -: 8]);
    for (int n = 0; n < 16; n++) b[n] = a[(n % 4) + 4 * (((n / 4) + (n % 4)) % 4)];
    if (!lastRound) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
        b[4*c]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
        b[4*c+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
        b[4*c+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
        b[4*c+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
      end
    end
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = b[n];
    return o ^ rk;
  endfunction

  // Datapath driven purely by the controller strobes.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (loadInit[i]) dpState[i] <= ptIn[i] ^ keyIn[i];
      if (keyLoad[i])  dpKey[i]   <= keyIn[i];
      if (roundEn[i])  dpState[i] <= aesRound(dpState[i], nextKey(dpKey[i], rcon[i]), bypass[i]);
      if (keyStep[i])  dpKey[i]   <= nextKey(dpKey[i], rcon[i]);
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- monitor: cycle model + scoreboard ----------------
  task automatic monitorStep(input int i);
    int rc;
    int k;
    int r;
    int qs;
    logic [18:0] expV;
    logic [18:0] actV;
    logic [18:0] msk;
    exp_t e;
    rc   = (i == 0) ? RC0 : RC1;
    k    = cyc - mAcc[i];
    expV = '0;
    msk  = '1;
    if (!rstN || !mBusy[i]) begin
      expV[18] = 1'b1;
    end else if (k == 1) begin
      expV[16] = 1'b1;
      expV[15] = 1'b1;
    end else if (k <= 1 + 10 * rc) begin
      r = (k - 2) / rc + 1;
      expV[14]   = ((k - 2) % rc == rc - 1);
      expV[13]   = expV[14];
      expV[12]   = (r == 10);
      expV[11:8] = 4'(r);
      expV[7:0]  = RCON[r];
    end else begin
      expV[17]   = 1'b1;
      expV[11:8] = 4'd10;
      msk[7:0]   = '0;
    end
    actV = {inReady[i], outValid[i], loadInit[i], keyLoad[i], roundEn[i], keyStep[i],
            bypass[i], roundNum[i], rcon[i]};
    chk($sformatf("ctrl[%0d] cyc %0d", i, cyc), 128'(actV & msk), 128'(expV & msk));

    if (rstN) begin
      if (inValid[i] && inReady[i]) begin
        accCyc[i] = cyc;
        reCnt[i]  = 0;
        liCnt[i]  = 0;
        outCnt[i] = 0;
      end
      if (roundEn[i])  reCnt[i]++;
      if (loadInit[i]) liCnt[i]++;
      if (outValid[i]) begin
        if (outCnt[i] == 0) firstOut[i] = cyc;
        outCnt[i]++;
        if (outReady[i]) begin
          qs = (i == 0) ? q0.size() : q1.size();
          chk($sformatf("sb[%0d] pending", i), 128'(qs != 0), 128'(1));
          if (qs != 0) begin
            if (i == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("sb[%0d] ciphertext", i), dpState[i], e.ct);
            chk($sformatf("sb[%0d] latency", i), 128'(firstOut[i] - accCyc[i]), 128'(e.lat));
            chk($sformatf("sb[%0d] outValid cycles", i), 128'(outCnt[i]), 128'(e.hold));
            chk($sformatf("sb[%0d] roundEn pulses", i), 128'(reCnt[i]), 128'(10));
            chk($sformatf("sb[%0d] loadInit pulses", i), 128'(liCnt[i]), 128'(1));
          end
          outCnt[i] = 0;
        end
      end
    end

    if (!rstN) begin
      mBusy[i] = 1'b0;
    end else if (!mBusy[i]) begin
      if (inValid[i]) begin
        mBusy[i] = 1'b1;
        mAcc[i]  = cyc;
      end
    end else if (abortIn[i]) begin
      mBusy[i] = 1'b0;
    end else if (k >= 2 + 10 * rc && outReady[i]) begin
      mBusy[i] = 1'b0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) monitorStep(i);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBlock(input int i, input logic [127:0] pt, input logic [127:0] key,
                           input logic [127:0] ct, input int hold);
    exp_t e;
    int   g;
    g = 0;
    while (!inReady[i] && g < 200) begin
      tick(1);
      g++;
    end
    chk($sformatf("ready before send[%0d]", i), 128'(inReady[i]), 128'(1));
    ptIn[i]    = pt;
    keyIn[i]   = key;
    inValid[i] = 1'b1;
    e.ct   = ct;
    e.lat  = 2 + 10 * ((i == 0) ? RC0 : RC1);
    e.hold = hold;
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    tick(1);
    inValid[i] = 1'b0;
  endtask

  task automatic waitDrain(input int i);
    int g;
    g = 0;
    while (((i == 0) ? q0.size() : q1.size()) != 0 && g < 200) begin
      tick(1);
      g++;
    end
    chk($sformatf("drain[%0d]", i), 128'((i == 0) ? q0.size() : q1.size()), 128'(0));
    tick(1);
  endtask

  initial begin
    int g;
    rstN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      inValid[i]  = 1'b0;
      outReady[i] = 1'b1;
      abortIn[i]  = 1'b0;
      ptIn[i]     = '0;
      keyIn[i]    = '0;
    end
    tick(3);
    rstN = 1'b1;

    // Accept on the very first cycle out of reset.
    sendBlock(0, PT_A, KEY_A, CT_A, 1);
    waitDrain(0);

    // Consumer stalls 5 cycles; a new request during OUT must be ignored.
    outReady[0] = 1'b0;
    sendBlock(0, PT_B, KEY_B, CT_B, 6);
    g = 0;
    while (!outValid[0] && g < 100) begin
      tick(1);
      g++;
    end
    chk("stall reached OUT", 128'(outValid[0]), 128'(1));
    inValid[0] = 1'b1;
    tick(5);
    outReady[0] = 1'b1;
    inValid[0]  = 1'b0;
    waitDrain(0);

    // Reset lands in round 5, then a fresh block must still encrypt correctly.
    sendBlock(0, PT_A, KEY_A, CT_A, 1);
    tick(5);
    rstN = 1'b0;
    q0.delete();
    tick(2);
    rstN = 1'b1;
    sendBlock(0, PT_B, KEY_B, CT_B, 1);
    waitDrain(0);

    // Three cycles per round.
    sendBlock(1, PT_A, KEY_A, CT_A, 1);
    waitDrain(1);

`ifdef AES_ROUND_CTRL_ABORT_EN
    sendBlock(0, PT_A, KEY_A, CT_A, 1);
    tick(7);
    abortIn[0] = 1'b1;
    q0.delete();
    tick(1);
    abortIn[0] = 1'b0;
    tick(2);
    chk("abort roundEn pulses", 128'(reCnt[0]), 128'(7));
`endif

    tick(3);
    chk("final queue[0]", 128'(q0.size()), 128'(0));
    chk("final queue[1]", 128'(q1.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter ROUND_CYCLES, default 1, legal values 1..4: clock cycles the datapath needs per round.
REQ-002 SHALL have port iClk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port iRsn, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port iInValid, input, 1 bit: a plaintext and key are present at the datapath.
REQ-005 SHALL have port oInReady, output, 1 bit: the controller accepts a new block.
REQ-006 SHALL have port oOutValid, output, 1 bit: the ciphertext in the datapath state register is final.
REQ-007 SHALL have port iOutReady, input, 1 bit: the consumer takes the ciphertext.
REQ-008 SHALL have port oLoadInit, output, 1 bit: load state register with plaintext XOR key (round 0).
REQ-009 SHALL have port oKeyLoad, output, 1 bit: load the key-expansion register with the cipher key.
REQ-010 SHALL have port oRoundEn, output, 1 bit: state register captures the round output (SubBytes, ShiftRows, MixColumns, AddRoundKey).
REQ-011 SHALL have port oKeyStep, output, 1 bit: key expansion advances one round key.
REQ-012 SHALL have port oRound, output, 4 bits: current round number.
REQ-013 SHALL have port oMixColBypass, output, 1 bit: skip MixColumns.
REQ-014 SHALL have port oRcon, output, 8 bits: round constant for the current round.

Function
REQ-015 SHALL implement FSM states IDLE, INIT, ROUND, OUT.
REQ-016 IDLE SHALL hold oInReady=1. On iInValid&&oInReady it SHALL move to INIT. All other outputs SHALL be 0 in IDLE.
REQ-017 INIT SHALL last one cycle, with oLoadInit=1, oKeyLoad=1, oRound=0 and oRcon=0x00. It SHALL then move to ROUND with round=1.
REQ-018 ROUND SHALL stay in each round for ROUND_CYCLES cycles, counted by a sub-cycle counter that restarts at 0 for every round.
REQ-019 oRoundEn and oKeyStep SHALL be 1 only on the last sub-cycle of each round.
REQ-020 On the last sub-cycle of round 10, ROUND SHALL move to OUT; on the last sub-cycle of rounds 1..9, round SHALL increment.
REQ-021 oMixColBypass SHALL be 1 only while in ROUND with oRound=10.
REQ-022 oRcon in ROUND SHALL follow the sequence 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.
REQ-023 OUT SHALL hold oOutValid=1 and oRound=10 until iOutReady=1, then move to IDLE. oOutValid SHALL be 1 for exactly the cycles in OUT.
REQ-024 oInReady SHALL be 0 outside IDLE; iInValid is ignored there. There is no overlap of blocks.
REQ-025 Latency: with the accept at cycle 0, oOutValid SHALL first be 1 at cycle 2+10*ROUND_CYCLES (cycle 12 for the default).
REQ-026 oRoundEn SHALL pulse exactly 10 times per block, and oLoadInit and oKeyLoad exactly once.
REQ-027 An illegal state encoding SHALL return to IDLE on the next cycle.

Reset
REQ-028 Asserting iRsn=0 SHALL immediately force IDLE, round=0, sub-cycle=0, oInReady=1 and all other outputs 0, including mid-block.
REQ-029 An interrupted block SHALL never produce oOutValid. The first cycle after deassertion SHALL be able to accept a new block.

Configuration
REQ-030 With macro AES_ROUND_CTRL_ABORT_EN defined, an input iAbort (1 bit) SHALL exist.
REQ-031 With AES_ROUND_CTRL_ABORT_EN, iAbort=1 in INIT, ROUND or OUT SHALL force IDLE on the next edge with no further oRoundEn and no oOutValid.
REQ-032 With AES_ROUND_CTRL_ABORT_EN, iAbort in IDLE SHALL be ignored, and a simultaneous accept SHALL proceed.
REQ-033 Without AES_ROUND_CTRL_ABORT_EN, port iAbort SHALL be absent and no abort logic SHALL exist.

Structure
REQ-034 Package aes_pkg SHALL hold: the FSM state encoding, constant NR=10, constant AES_BLOCK_W=128, and the Rcon table.
REQ-035 Sub-module aes_rcon_gen SHALL produce oRcon from the round number, combinationally, with output 0x00 for round 0 and for rounds above 10.

Verification
REQ-036 Reset, then iInValid=1 at cycle 0 -> oLoadInit at cycle 1, oRoundEn at cycles 2..11, oMixColBypass at cycle 11, oOutValid from cycle 12.
REQ-037 ROUND_CYCLES=3 -> oRoundEn every third cycle, 10 pulses, oOutValid at cycle 32.
REQ-038 With datapath attached, plaintext 00112233445566778899aabbccddeeff and key 000102030405060708090a0b0c0d0e0f -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-039 iOutReady held 0 for 5 cycles in OUT -> oOutValid stable for 6 cycles, iInValid ignored, IDLE after iOutReady=1.
REQ-040 iRsn=0 at round 5 -> all outputs reset at once, no oOutValid, next block completes with correct ciphertext.
REQ-041 With AES_ROUND_CTRL_ABORT_EN, iAbort=1 at round 7 -> IDLE next cycle, oRoundEn count 7, no oOutValid.
